// File: rtl/io_switch_port.sv
// io_switch_port: four debounced push-buttons feeding a small event FIFO,
// read by the CPU through a data port (PORT_BASE) and a status/control
// port (PORT_BASE+1). o_Irq is high whenever events are waiting.
module io_switch_port #(
  parameter int         DEBOUNCE_CYCLES = 250000,
  parameter int         DEPTH           = 4,
  parameter logic [7:0] PORT_BASE       = 8'h10
) (
  input  logic       i_Clk,
  input  logic       reset_n,
  input  logic       ioreq,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] data_in,
  input  logic [3:0] i_Switch,
  output logic [7:0] data_out,
  output logic       o_Irq
);

  localparam int             CW          = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int             AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]  CNT_MAX     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0]    DEPTH_C     = (AW + 1)'(DEPTH);
  localparam logic [7:0]     STATUS_ADDR = PORT_BASE + 8'd1;

  // Synchronizer and debounce state
  logic [3:0]         sync1_q, sync2_q;
  logic [3:0]         stable_q, stable_d;
  logic [3:0][CW-1:0] cnt_q, cnt_d;
  logic [3:0]         press_edge, rel_edge;

  // Pending events and overflow
  logic [3:0] pend_press_q, pend_press_d;
  logic [3:0] pend_rel_q, pend_rel_d;
  logic       ovf_q, ovf_d;
  logic [3:0] sel_press, sel_rel;
  logic       ovf_new;

  // FIFO
  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop, empty, full;
  logic [7:0]    push_byte;

  // CPU side
  logic       data_rd, stat_rd, flush;
  logic [7:0] data_out_q, data_out_d;
  logic       irq_q;
  logic [7:0] count_ext;
  logic [2:0] count3;
  logic       unused_data_bits;

  assign unused_data_bits = ^data_in[7:1];

  // Two-flop synchronizer on the raw button levels
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_Clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_Switch;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYCLES consecutive disagreeing cycles
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    press_edge = stable_d & ~stable_q;
    rel_edge   = ~stable_d & stable_q;
  end

  // IO decode and FIFO status
  always_comb begin
    data_rd = ioreq && !we && (addr == PORT_BASE);
    stat_rd = ioreq && !we && (addr == STATUS_ADDR);
    flush   = ioreq && we && (addr == STATUS_ADDR) && data_in[0];
    empty   = (count_q == '0);
    full    = (count_q == DEPTH_C);
    pop     = data_rd && !empty;
  end

  // Pick one pending event (presses first, then lowest index) and update pending/overflow
  always_comb begin
    sel_press = '0;
    sel_rel   = '0;
    push      = 1'b0;
    push_byte = '0;
    if (!flush && (!full || pop)) begin
      if (|pend_press_q) begin
        for (int i = 3; i >= 0; i--) begin
          if (pend_press_q[i]) begin
            sel_press = '0;
            sel_press[i] = 1'b1;
            push_byte = {1'b1, 5'b00000, 2'(i)};
          end
        end
        push = 1'b1;
      end else if (|pend_rel_q) begin
        for (int i = 3; i >= 0; i--) begin
          if (pend_rel_q[i]) begin
            sel_rel = '0;
            sel_rel[i] = 1'b1;
            push_byte = {1'b0, 5'b00000, 2'(i)};
          end
        end
        push = 1'b1;
      end
    end

    // A bit being enqueued this cycle is free to take a new edge without overflow.
    ovf_new = |((press_edge & pend_press_q & ~sel_press) |
                (rel_edge & pend_rel_q & ~sel_rel));
    pend_press_d = (pend_press_q & ~sel_press) | press_edge;
    pend_rel_d   = (pend_rel_q & ~sel_rel) | rel_edge;
    if (flush) begin
      pend_press_d = '0;
      pend_rel_d   = '0;
    end
    // A newly detected overflow beats the clear-on-read.
    ovf_d = (ovf_q && !stat_rd) || ovf_new;
  end

  // FIFO pointers, occupancy and the registered read data
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop) count_d = count_q + (AW + 1)'(1);
      if (pop && !push) count_d = count_q - (AW + 1)'(1);
    end

    count_ext = 8'(count_q);
    count3    = (count_ext > 8'd7) ? 3'd7 : count_ext[2:0];

    data_out_d = data_out_q;
    if (data_rd) begin
      data_out_d = empty ? 8'h00 : mem[rd_ptr_q];
    end else if (stat_rd) begin
      data_out_d = {ovf_q, count3, stable_q};
    end
  end

  // Event storage
  // NOTE: the FIFO array is not reset; count and pointers alone decide what is valid.
  always_ff @(posedge i_Clk) begin
    if (push) mem[wr_ptr_q] <= push_byte;
  end

  // State registers
  always_ff @(posedge i_Clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q     <= '0;
      cnt_q        <= '0;
      pend_press_q <= '0;
      pend_rel_q   <= '0;
      ovf_q        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_out_q   <= 8'h00;
      irq_q        <= 1'b0;
    end else begin
      stable_q     <= stable_d;
      cnt_q        <= cnt_d;
      pend_press_q <= pend_press_d;
      pend_rel_q   <= pend_rel_d;
      ovf_q        <= ovf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      irq_q        <= (count_d != '0);
    end
  end

  assign data_out = data_out_q;
  assign o_Irq    = irq_q;

endmodule

// File: tb/tb_io_switch_port.sv
// Testbench for io_switch_port (DEBOUNCE_CYCLES=4, DEPTH=4, PORT_BASE=8'h10).
// Reads push their expected byte into a scoreboard queue; a monitor compares
// data_out on the falling edge after each read edge.
module tb_io_switch_port;

  logic       i_Clk    = 1'b0;
  logic       reset_n  = 1'b0;
  logic       ioreq    = 1'b0;
  logic       we       = 1'b0;
  logic [7:0] addr     = 8'h00;
  logic [7:0] data_in  = 8'h00;
  logic [3:0] i_Switch = 4'h0;
  logic [7:0] data_out;
  logic       o_Irq;

  io_switch_port #(
    .DEBOUNCE_CYCLES(4),
    .DEPTH(4),
    .PORT_BASE(8'h10)
  ) dut (
    .i_Clk(i_Clk),
    .reset_n(reset_n),
    .ioreq(ioreq),
    .we(we),
    .addr(addr),
    .data_in(data_in),
    .i_Switch(i_Switch),
    .data_out(data_out),
    .o_Irq(o_Irq)
  );

  always #5 i_Clk = ~i_Clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];
  string      name_q[$];
  logic       rd_seen = 1'b0;

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Remember that a read was presented on the last rising edge
  always @(posedge i_Clk or negedge reset_n) begin
    if (!reset_n) rd_seen <= 1'b0;
    else rd_seen <= ioreq && !we && (addr == 8'h10 || addr == 8'h11);
  end

  // Monitor: compare read data against the scoreboard head
  always @(negedge i_Clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_read: got %h expected no read", data_out);
      end else begin
        check(name_q.pop_front(), data_out, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  task automatic io_read(input logic [7:0] a, input logic [7:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    ioreq = 1'b1; we = 1'b0; addr = a;
    @(negedge i_Clk);
    ioreq = 1'b0; addr = 8'h00;
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    ioreq = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(negedge i_Clk);
    ioreq = 1'b0; we = 1'b0; addr = 8'h00; data_in = 8'h00;
  endtask

  task automatic wait_irq(input int max, input string nm);
    for (int i = 0; i < max && !o_Irq; i++) @(negedge i_Clk);
    check(nm, {7'b0, o_Irq}, 8'h01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(3);
    check("reset_data_out", data_out, 8'h00);
    check("reset_irq", {7'b0, o_Irq}, 8'h00);
    reset_n = 1'b1;
    tick(2);

    // Clean press of switch 2: irq within 8 cycles, then pop 0x82
    i_Switch = 4'b0100;
    wait_irq(8, "irq_press2_latency");
    io_read(8'h11, 8'h14, "status_one_event");
    io_read(8'h10, 8'h82, "pop_press2");
    check("irq_after_pop", {7'b0, o_Irq}, 8'h00);
    i_Switch = 4'b0000;
    wait_irq(12, "irq_release2");
    io_read(8'h10, 8'h02, "pop_release2");
    check("irq_after_release_pop", {7'b0, o_Irq}, 8'h00);

    // Bouncing switch 0 never settles: no events
    for (int i = 0; i < 10; i++) begin
      i_Switch[0] = ~i_Switch[0];
      tick(2);
    end
    tick(10);
    io_read(8'h11, 8'h00, "status_after_bounce");
    check("irq_after_bounce", {7'b0, o_Irq}, 8'h00);

    // Simultaneous press of switches 1 and 3
    i_Switch = 4'b1010;
    wait_irq(12, "irq_press13");
    tick(3);
    io_read(8'h11, 8'h2A, "status_two_events");
    io_read(8'h10, 8'h81, "pop_press1");
    io_read(8'h10, 8'h83, "pop_press3");
    io_read(8'h10, 8'h00, "pop_empty");
    check("irq_empty", {7'b0, o_Irq}, 8'h00);

    // Queue three events, check ignored writes, then flush
    i_Switch = 4'b0000;
    tick(10);
    i_Switch = 4'b0001;
    tick(10);
    io_read(8'h11, 8'h31, "status_three_events");
    check("irq_three_events", {7'b0, o_Irq}, 8'h01);
    io_write(8'h10, 8'hFF);
    io_write(8'h11, 8'h00);
    io_write(8'h20, 8'h01);
    check("data_out_hold_on_write", data_out, 8'h31);
    io_read(8'h11, 8'h31, "status_after_ignored_writes");
    io_write(8'h11, 8'h01);
    check("irq_after_flush", {7'b0, o_Irq}, 8'h00);
    io_read(8'h11, 8'h01, "status_after_flush");
    i_Switch = 4'b0000;
    tick(10);
    io_read(8'h11, 8'h10, "status_release0_queued");
    io_read(8'h10, 8'h00, "pop_release0");
    io_read(8'h11, 8'h00, "status_drained");

    // Fill the FIFO, hold two pending releases, then force an overflow
    i_Switch = 4'b1111;
    tick(12);
    i_Switch = 4'b1100;
    tick(10);
    io_read(8'h11, 8'h4C, "status_full");
    check("irq_full", {7'b0, o_Irq}, 8'h01);
    i_Switch = 4'b1101;
    tick(10);
    i_Switch = 4'b1100;
    tick(10);
    io_read(8'h11, 8'hCC, "status_overflow_set");
    io_read(8'h11, 8'h4C, "status_overflow_cleared");
    io_read(8'h10, 8'h80, "pop_full_press0");
    tick(2);
    io_read(8'h11, 8'h4C, "status_refilled");
    io_read(8'h10, 8'h81, "pop_press1_b"); tick(2);
    io_read(8'h10, 8'h82, "pop_press2_b"); tick(2);
    io_read(8'h10, 8'h83, "pop_press3_b"); tick(2);
    io_read(8'h10, 8'h80, "pop_press0_late"); tick(2);
    io_read(8'h10, 8'h00, "pop_release0_late"); tick(2);
    io_read(8'h10, 8'h01, "pop_release1_late"); tick(2);
    io_read(8'h11, 8'h0C, "status_after_overflow_drain");

    // Reset in the middle of debouncing switch 1
    i_Switch = 4'b0000;
    tick(10);
    io_read(8'h11, 8'h20, "status_before_reset");
    i_Switch = 4'b0010;
    tick(3);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_data_out", data_out, 8'h00);
    check("async_reset_irq", {7'b0, o_Irq}, 8'h00);
    @(negedge i_Clk);
    tick(2);
    reset_n = 1'b1;
    wait_irq(12, "irq_press1_after_reset");
    io_read(8'h10, 8'h81, "pop_press1_after_reset");
    tick(10);
    io_read(8'h10, 8'h00, "pop_empty_after_reset");
    io_read(8'h11, 8'h02, "status_after_reset");
    tick(2);

    check("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/io_switch_port.md
IO_SWITCH_PORT -- requirements
Module: io_switch_port

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, meaning the number of cycles an input must be stable before it is accepted (10 ms at 25 MHz).
REQ-002 SHALL have parameter DEPTH, default 4, meaning the event FIFO depth; power of two, 2..16.
REQ-003 SHALL have parameter PORT_BASE, default 8'h10, meaning the IO address of the data port; the status port is PORT_BASE+1.
REQ-004 i_Clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 ioreq  input  1  CPU IO cycle qualifier.
REQ-007 we  input  1  1 = IO write, 0 = IO read.
REQ-008 addr  input  8  IO port number (CPU addr[7:0]).
REQ-009 data_in  input  8  CPU write data.
REQ-010 i_Switch  input  4  raw, asynchronous push-button levels; 1 = pressed.
REQ-011 data_out  output  8  registered IO read data.
REQ-012 o_Irq  output  1  high while the FIFO is non-empty.

Function
REQ-013 Each i_Switch bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Per switch: a counter SHALL clear whenever the synchronized level equals the stable level; otherwise it increments, and on reaching DEBOUNCE_CYCLES-1 the stable level SHALL take the synchronized level and the counter SHALL clear.
REQ-015 A stable 0->1 change SHALL set pending-press[i]; a stable 1->0 change SHALL set pending-release[i].
REQ-016 If an edge occurs while its own pending bit is already set, the overflow flag SHALL be set and the pending bit SHALL stay set (single event retained).
REQ-017 At most one pending bit is enqueued per cycle, only when the FIFO is not full. Priority: press before release, then lowest switch index. The enqueued bit is cleared in the same cycle.
REQ-018 Event byte SHALL be {press(1 = press, 0 = release), 5'b00000, index[1:0]}.
REQ-019 An IO read of PORT_BASE (ioreq=1, we=0) SHALL pop the FIFO head into data_out on the next rising edge. If the FIFO is empty, data_out SHALL load 8'h00 and no pop occurs.
REQ-020 An IO read of PORT_BASE+1 SHALL load data_out with {overflow, count[2:0], stable[3:0]} and clear overflow on the same edge. count saturates its encoding at 7 when DEPTH>7; an overflow set on that same edge wins.
REQ-021 An IO write to PORT_BASE+1 with data_in[0]=1 SHALL flush the FIFO (count=0) and clear all pending bits. All other IO writes, and all accesses to other addresses, SHALL be ignored; data_out holds.
REQ-022 A read uses pre-edge FIFO state. A simultaneous push and pop, including when full, SHALL both occur with count unchanged. A push into an empty FIFO is not visible to a read on that same edge.
REQ-023 Pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-024 o_Irq SHALL be registered, equal to (count!=0) after each edge.

Reset
REQ-025 reset_n=0 SHALL asynchronously clear synchronizers, stable levels, counters, pending bits, pointers, count, overflow, data_out (8'h00) and o_Irq (0).
REQ-026 Reset SHALL be honoured mid-debounce and mid-read. After release, no event SHALL be generated for a switch held low, and a switch held high SHALL produce exactly one press once debounced.

Verification (DEBOUNCE_CYCLES=4, DEPTH=4, PORT_BASE=8'h10)
REQ-027 Press switch 2 cleanly -> o_Irq rises within 2+4+2 cycles. Read 0x10 -> data_out=8'h82, then o_Irq=0.
REQ-028 Toggle switch 0 every 2 cycles for 20 cycles, then hold 0 -> no events, count stays 0.
REQ-029 Press switches 1 and 3 in the same cycle -> FIFO order 8'h81 then 8'h83. Status read -> 8'h2A (count 2, stable 1010).
REQ-030 With no reads, generate 6 events -> count=4, pending holds 2. Pop one -> next pending enqueued the following cycle, count returns to 4. A repeated edge on a pending switch -> status bit7=1, and the next status read shows bit7=0.
REQ-031 Read 0x10 when empty -> data_out=8'h00. Write 8'h01 to 0x11 with 3 events queued -> count=0, o_Irq=0.
REQ-032 Assert reset_n=0 mid-debounce with switch 1 held high -> all outputs 0 immediately. After release, exactly one 8'h81 is queued.
